// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op and state encodings shared by iter_shifter and shift_step
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter, moves acc by k<=STEP bits
// op=11 rotates right when ITER_SHIFTER_ROTATE_EN is defined, otherwise decodes as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] result
);

`ifdef ITER_SHIFTER_ROTATE_EN
  // Shifting the doubled word brings the low bits back in at the top.
  logic [2*WIDTH-1:0] rot;
  assign rot = {acc, acc} >> k;
`endif

  always_comb begin
    result = acc << k;
    case (op)
      OP_SRL: result = acc >> k;
      OP_SRA: result = $signed(acc) >>> k;
`ifdef ITER_SHIFTER_ROTATE_EN
      OP_ROR: result = rot[WIDTH-1:0];
`endif
      default: result = acc << k;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter, up to STEP bits per clock, busy/done handshake
// Optional rotate-right on op=11 under ITER_SHIFTER_ROTATE_EN.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           data_out
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int KW      = $clog2(STEP + 1);
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic [SHAMT_W-1:0]   rem;
  logic [1:0]           op_q;

  logic [SHAMT_W:0]     rem_w;
  logic [KW-1:0]        step_k;
  logic [SHAMT_W-1:0]   rem_next;
  logic [WIDTH-1:0]     step_out;

  // STEP may equal WIDTH, which needs one more bit than rem can hold.
  assign rem_w    = {1'b0, rem};
  assign step_k   = (rem_w >= STEP_W) ? KW'(STEP) : KW'(rem_w);
  assign rem_next = rem - SHAMT_W'(step_k);

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .acc    (acc),
    .op     (op_q),
    .k      (step_k),
    .result (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      acc      <= '0;
      rem      <= '0;
      op_q     <= OP_SLL;
    end else begin
      case (state)
        SHIFT: begin
          acc <= step_out;
          rem <= rem_next;
          if (rem_next == '0) begin
            data_out <= step_out;
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept, so DONE can chain straight into a new shift.
          if (start) begin
            acc  <= data_in;
            rem  <= shamt;
            op_q <= op;
            if (shamt == '0) begin
              data_out <= data_in;
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle, parametrised shift unit for the pipeline's EX-stage shift instructions (sll/srl/sra and variable forms). Supersedes the fixed constant left-shift used for branch/jump offsets.
- Shift amount and direction are chosen at run time.
- The unit shifts at most STEP bits per clock and reports completion with a busy/done handshake.
- Hazard logic stalls the pipeline while busy is high.

Parameters:
WIDTH, 32, data width in bits (>=2)
STEP, 1, max bits shifted per cycle; power of 2, 1..WIDTH
SHAMT_W, localparam = $clog2(WIDTH), shift-amount width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 see Optional Feature
shamt  input  SHAMT_W  shift amount, unsigned
data_in  input  WIDTH  operand
busy  output  1  high while a shift is in progress
done  output  1  one-cycle pulse, result valid
data_out  output  WIDTH  registered result, held until the next completion

Behaviour:
- Reset (asynchronous, active-high, any state):
  - state=IDLE; busy=0; done=0; data_out=0; internal acc and rem cleared.
  - Mid-operation reset aborts the shift; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- Accept: start=1 while busy=0 (IDLE or DONE) at an edge.
  - Loads acc=data_in, rem=shamt, and latches op.
  - If shamt==0: next state DONE. Otherwise next state SHIFT.
- SHIFT, each edge:
  - k=min(STEP,rem); acc shifted by k per the latched op; rem=rem-k.
  - If rem-k==0: data_out<=shifted acc, next state DONE. Otherwise stay in SHIFT.
- shamt==0 path: data_out<=data_in on the transition into DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - If start=1 that edge: accept the new request (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
- busy=1 exactly while state==SHIFT. start while busy is ignored and inputs are not re-sampled.
- Latency: done is high in the cycle after edge 1+ceil(shamt/STEP), counting the accept edge as edge 1.
  - shamt=0: done one cycle after accept.
  - WIDTH=32, STEP=1, shamt=31: done after 32 edges.
- Arithmetic:
  - SLL fills zeros at the LSB; SRL fills zeros at the MSB.
  - SRA replicates the bit that is currently in acc[WIDTH-1] on every step, so the sign is preserved across steps.
- data_out changes only on entry to DONE (or on reset). It is stable in IDLE, SHIFT and DONE.

Optional Feature:
Macro: ITER_SHIFTER_ROTATE_EN
- Defined: op=11 is rotate-right. The k bits leaving the LSB re-enter at the MSB each step.
- Undefined: op=11 decodes as SLL; no rotate logic is synthesised.

Decomposition:
- Package shift_pkg:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11;
  - state encoding IDLE/SHIFT/DONE.
- Sub-module shift_step: combinational single-step shifter (acc, op, k<=STEP) -> shifted acc.
  - Instantiated once in the datapath.
  - Contains the rotate path under the macro.

Test Plan:
- WIDTH=32, STEP=1, SLL 0x00000001, shamt=31 -> busy high for 31 cycles; done after edge 32; data_out=0x80000000.
- SRA 0x80000000, shamt=4 -> 0xF8000000. SRL of the same operand -> 0x08000000.
- shamt=0, data_in=0x12345678 -> done one cycle after accept with data_out=0x12345678. A start asserted during that done cycle is accepted immediately.
- start pulsed while busy with different data -> ignored, original result delivered. Reset asserted mid-SHIFT -> busy/done/data_out=0 immediately; a fresh start then completes correctly.
- STEP=4, SRL 0xFFFFFFFF, shamt=7 -> exactly 2 SHIFT cycles; data_out=0x01FFFFFF.
- op=11, data_in=0x000000F1, shamt=4:
  - with ITER_SHIFTER_ROTATE_EN -> 0x1000000F;
  - without the macro -> 0x00000F10.
